// File: rtl/line_mem_arbiter.sv
// -----------------------------------------------------------------------------
// line_mem_arbiter
//
// Purpose:
//    Arbitrates one line request at a time between the I-side and D-side line
//    caches and turns each grant into a BEATS-beat burst on the memory port.
//    Read beats are assembled into line_buf. The owning side sees a one-cycle
//    completion pulse in the DONE state that follows the last beat.
//    Fixed priority at IDLE: D write, then D read, then I read.
//
// Ports:
//    clk, rst                   clock, asynchronous active-low reset
//    i_line_read/addr           I-side line read request (held until resp)
//    i_line_rdata/resp          I-side returned line and completion pulse
//    d_line_read/write/addr     D-side read / writeback request (held until resp)
//    d_line_wdata               D-side writeback line
//    d_line_rdata/resp          D-side returned line and completion pulse
//    mem_read/mem_write         burst active (registered state outputs)
//    mem_addr                   line-aligned burst base address, 0 when idle
//    mem_wdata                  current write beat, selected by the beat counter
//    mem_rdata/mem_resp         memory beat data and beat handshake
// -----------------------------------------------------------------------------
module line_mem_arbiter #(
   parameter  int BEATS  = 4,
   parameter  int BEAT_W = 64,
   localparam int LINE_W = BEATS * BEAT_W
) (
   input  logic              clk,
   input  logic              rst,

   input  logic              i_line_read,
   input  logic [31:0]       i_line_addr,
   output logic [LINE_W-1:0] i_line_rdata,
   output logic              i_line_resp,

   input  logic              d_line_read,
   input  logic              d_line_write,
   input  logic [31:0]       d_line_addr,
   input  logic [LINE_W-1:0] d_line_wdata,
   output logic [LINE_W-1:0] d_line_rdata,
   output logic              d_line_resp,

   output logic              mem_read,
   output logic              mem_write,
   output logic [31:0]       mem_addr,
   output logic [BEAT_W-1:0] mem_wdata,
   input  logic [BEAT_W-1:0] mem_rdata,
   input  logic              mem_resp
);

   localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int OFF_W = $clog2(LINE_W / 8);

   localparam logic [31:0]      ALIGN_MASK = ~((32'd1 << OFF_W) - 32'd1);
   localparam logic [CNT_W-1:0] LAST_BEAT  = CNT_W'(BEATS - 1);

   typedef enum logic [2:0] {
      IDLE,
      I_RD,
      D_RD,
      D_WR,
      DONE
   } state_t;

   state_t            state;
   logic [CNT_W-1:0]  cnt;
   logic [31:0]       addr;
   logic [LINE_W-1:0] line_buf;
   logic [LINE_W-1:0] wr_buf;

   // NOTE: sequential state is updated with non-blocking assignments only, so
   // every register in this block sees the pre-edge value of every other one.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         cnt         <= '0;
         addr        <= '0;
         // NOTE: line_buf and wr_buf are wide data registers, not RAMs; they are
         // reset explicitly because the returned-line outputs must read 0.
         line_buf    <= '0;
         wr_buf      <= '0;
         mem_read    <= 1'b0;
         mem_write   <= 1'b0;
         i_line_resp <= 1'b0;
         d_line_resp <= 1'b0;
      end else begin
         // Completion pulses last exactly one cycle (the DONE cycle).
         i_line_resp <= 1'b0;
         d_line_resp <= 1'b0;

         case (state)
            IDLE: begin
               if (d_line_write) begin
                  state     <= D_WR;
                  mem_write <= 1'b1;
                  addr      <= d_line_addr & ALIGN_MASK;
                  wr_buf    <= d_line_wdata;
                  cnt       <= '0;
               end else if (d_line_read) begin
                  state    <= D_RD;
                  mem_read <= 1'b1;
                  addr     <= d_line_addr & ALIGN_MASK;
                  cnt      <= '0;
               end else if (i_line_read) begin
                  state    <= I_RD;
                  mem_read <= 1'b1;
                  addr     <= i_line_addr & ALIGN_MASK;
                  cnt      <= '0;
               end
            end

            I_RD, D_RD, D_WR: begin
               // Without mem_resp the beat counter holds and the burst stays up.
               if (mem_resp) begin
                  if (state != D_WR) begin
                     line_buf[cnt*BEAT_W +: BEAT_W] <= mem_rdata;
                  end
                  cnt <= cnt + 1'b1;
                  if (cnt == LAST_BEAT) begin
                     state       <= DONE;
                     mem_read    <= 1'b0;
                     mem_write   <= 1'b0;
                     i_line_resp <= (state == I_RD);
                     d_line_resp <= (state != I_RD);
                  end
               end
            end

            // One cycle here keeps a still-high request from being re-granted
            // on the same edge its response is seen.
            DONE: state <= IDLE;

            default: state <= IDLE;
         endcase
      end
   end

   // Address is only presented while a burst is active.
   assign mem_addr  = (mem_read || mem_write) ? addr : 32'd0;
   assign mem_wdata = wr_buf[cnt*BEAT_W +: BEAT_W];

   assign i_line_rdata = line_buf;
   assign d_line_rdata = line_buf;

endmodule

// File: tb/tb_line_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_line_mem_arbiter
//
// Self-checking bench for line_mem_arbiter. Inputs are driven and outputs are
// sampled on the falling clock edge. The reference model tracks the expected
// returned line and, per burst, the expected address, write beats and the
// cycle on which the completion pulse appears.
// -----------------------------------------------------------------------------
module tb_line_mem_arbiter;

   localparam int BEATS  = 4;
   localparam int BEAT_W = 64;
   localparam int LINE_W = BEATS * BEAT_W;

   localparam int K_IRD = 0;
   localparam int K_DRD = 1;
   localparam int K_DWR = 2;

   logic              clk;
   logic              rst;
   logic              i_line_read;
   logic [31:0]       i_line_addr;
   logic [LINE_W-1:0] i_line_rdata;
   logic              i_line_resp;
   logic              d_line_read;
   logic              d_line_write;
   logic [31:0]       d_line_addr;
   logic [LINE_W-1:0] d_line_wdata;
   logic [LINE_W-1:0] d_line_rdata;
   logic              d_line_resp;
   logic              mem_read;
   logic              mem_write;
   logic [31:0]       mem_addr;
   logic [BEAT_W-1:0] mem_wdata;
   logic [BEAT_W-1:0] mem_rdata;
   logic              mem_resp;

   int n_vec = 0;
   int n_err = 0;

   // Reference model state.
   logic [LINE_W-1:0] exp_line;
   logic [BEAT_W-1:0] beat_src [BEATS];

   line_mem_arbiter #(.BEATS(BEATS), .BEAT_W(BEAT_W)) dut (
      .clk          (clk),
      .rst          (rst),
      .i_line_read  (i_line_read),
      .i_line_addr  (i_line_addr),
      .i_line_rdata (i_line_rdata),
      .i_line_resp  (i_line_resp),
      .d_line_read  (d_line_read),
      .d_line_write (d_line_write),
      .d_line_addr  (d_line_addr),
      .d_line_wdata (d_line_wdata),
      .d_line_rdata (d_line_rdata),
      .d_line_resp  (d_line_resp),
      .mem_read     (mem_read),
      .mem_write    (mem_write),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_rdata    (mem_rdata),
      .mem_resp     (mem_resp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [LINE_W-1:0] got,
                        input logic [LINE_W-1:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [LINE_W-1:0] rand_line();
      logic [LINE_W-1:0] l;
      for (int k = 0; k < LINE_W / 32; k++) l[k*32 +: 32] = $urandom;
      return l;
   endfunction

   task automatic rand_beats();
      for (int b = 0; b < BEATS; b++) beat_src[b] = {$urandom, $urandom};
   endtask

   task automatic check_idle(input string tag);
      check({tag, ".mem_read"},  mem_read,  1'b0);
      check({tag, ".mem_write"}, mem_write, 1'b0);
      check({tag, ".mem_addr"},  mem_addr,  32'd0);
      check({tag, ".i_resp"},    i_line_resp, 1'b0);
      check({tag, ".d_resp"},    d_line_resp, 1'b0);
      check({tag, ".i_rdata"},   i_line_rdata, exp_line);
      check({tag, ".d_rdata"},   d_line_rdata, exp_line);
   endtask

   // Called at a falling edge with the request already driven, so the next
   // rising edge grants it. Returns at the falling edge of the IDLE cycle
   // after DONE. fixed_gap >= 0 forces that many idle cycles before each beat.
   task automatic run_burst(input int kind, input logic [31:0] a,
                            input logic [LINE_W-1:0] wd, input int max_gap,
                            input int fixed_gap);
      logic [LINE_W-1:0] assembled;
      int gap;
      assembled = exp_line;
      @(negedge clk);
      // Requester inputs move after grant; the DUT must ignore them.
      if (kind == K_IRD) begin
         i_line_addr = $urandom;
      end else begin
         d_line_addr  = 32'hFFFF_FFE0;
         d_line_wdata = rand_line();
      end
      for (int b = 0; b < BEATS; b++) begin
         gap = (fixed_gap >= 0) ? fixed_gap : $urandom_range(0, max_gap);
         for (int g = 0; g <= gap; g++) begin
            check("burst.mem_read",  mem_read,  kind != K_DWR);
            check("burst.mem_write", mem_write, kind == K_DWR);
            check("burst.mem_addr",  mem_addr,  a & 32'hFFFF_FFE0);
            check("burst.i_resp",    i_line_resp, 1'b0);
            check("burst.d_resp",    d_line_resp, 1'b0);
            if (kind == K_DWR) check("burst.mem_wdata", mem_wdata, wd[b*BEAT_W +: BEAT_W]);
            if (g == gap) begin
               mem_resp  = 1'b1;
               mem_rdata = beat_src[b];
            end else begin
               mem_resp  = 1'b0;
               mem_rdata = {$urandom, $urandom};
            end
            @(negedge clk);
         end
         if (kind != K_DWR) assembled[b*BEAT_W +: BEAT_W] = beat_src[b];
      end
      exp_line = assembled;
      // DONE cycle: a stray beat handshake here must be ignored.
      mem_resp  = 1'($urandom_range(0, 1));
      mem_rdata = {$urandom, $urandom};
      check("done.i_resp",    i_line_resp, kind == K_IRD);
      check("done.d_resp",    d_line_resp, kind != K_IRD);
      check("done.mem_read",  mem_read,  1'b0);
      check("done.mem_write", mem_write, 1'b0);
      check("done.mem_addr",  mem_addr,  32'd0);
      check("done.i_rdata",   i_line_rdata, exp_line);
      check("done.d_rdata",   d_line_rdata, exp_line);
      if (kind == K_IRD) i_line_read = 1'b0;
      else begin
         d_line_read  = 1'b0;
         d_line_write = 1'b0;
      end
      @(negedge clk);
      mem_resp = 1'b0;
      check_idle("post");
   endtask

   initial begin
      logic [31:0]       a;
      logic [31:0]       ia;
      logic [LINE_W-1:0] wd;
      int                kind;

      rst          = 1'b0;
      i_line_read  = 1'b0;
      i_line_addr  = '0;
      d_line_read  = 1'b0;
      d_line_write = 1'b0;
      d_line_addr  = '0;
      d_line_wdata = '0;
      mem_rdata    = '0;
      mem_resp     = 1'b0;
      exp_line     = '0;

      // Reset state.
      @(negedge clk);
      @(negedge clk);
      check_idle("reset");
      check("reset.mem_wdata", mem_wdata, 64'd0);
      rst = 1'b1;
      @(negedge clk);

      // Directed I read: address 0x64 aligns to 0x60, beats back-to-back.
      beat_src[0] = 64'h1111_1111_1111_1111;
      beat_src[1] = 64'h2222_2222_2222_2222;
      beat_src[2] = 64'h3333_3333_3333_3333;
      beat_src[3] = 64'h4444_4444_4444_4444;
      i_line_read = 1'b1;
      i_line_addr = 32'h0000_0064;
      run_burst(K_IRD, 32'h0000_0064, '0, 0, 0);
      check("dir.i_line", i_line_rdata,
            {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
             64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});

      // Directed D write with 2-cycle gaps before each beat.
      wd = {64'hDDDD_0000_0000_0004, 64'hCCCC_0000_0000_0003,
            64'hBBBB_0000_0000_0002, 64'hAAAA_0000_0000_0001};
      rand_beats();
      d_line_write = 1'b1;
      d_line_addr  = 32'h0000_1000;
      d_line_wdata = wd;
      run_burst(K_DWR, 32'h0000_1000, wd, 0, 2);

      // Simultaneous I and D reads: D first, I follows after DONE + IDLE.
      rand_beats();
      d_line_read = 1'b1;
      d_line_addr = 32'h0000_2040;
      i_line_read = 1'b1;
      i_line_addr = 32'h0000_3088;
      run_burst(K_DRD, 32'h0000_2040, '0, 1, -1);
      rand_beats();
      run_burst(K_IRD, 32'h0000_3088, '0, 1, -1);

      // mem_resp while IDLE is ignored.
      mem_resp  = 1'b1;
      mem_rdata = {$urandom, $urandom};
      @(negedge clk);
      mem_resp = 1'b0;
      check_idle("idle_resp");
      @(negedge clk);
      check_idle("idle_resp2");

      // Reset after two beats of an I read.
      rand_beats();
      a = $urandom;
      i_line_read = 1'b1;
      i_line_addr = a;
      @(negedge clk);
      for (int b = 0; b < 2; b++) begin
         mem_resp  = 1'b1;
         mem_rdata = {$urandom, $urandom};
         @(negedge clk);
      end
      mem_resp = 1'b0;
      check("mid.mem_read", mem_read, 1'b1);
      #2 rst = 1'b0;
      #1;
      exp_line = '0;
      check("rst_async.mem_read", mem_read, 1'b0);
      check("rst_async.mem_addr", mem_addr, 32'd0);
      check("rst_async.i_resp",   i_line_resp, 1'b0);
      check("rst_async.i_rdata",  i_line_rdata, exp_line);
      @(negedge clk);
      check_idle("rst_hold");
      rst = 1'b1;
      rand_beats();
      run_burst(K_IRD, a, '0, 0, 0);

      // Randomized transactions, sometimes with a competing I request.
      for (int t = 0; t < 24; t++) begin
         kind = $urandom_range(0, 2);
         a    = $urandom;
         wd   = rand_line();
         rand_beats();
         if (kind == K_IRD) begin
            i_line_read = 1'b1;
            i_line_addr = a;
            run_burst(K_IRD, a, '0, 3, -1);
         end else begin
            d_line_read  = (kind == K_DRD);
            d_line_write = (kind == K_DWR);
            d_line_addr  = a;
            d_line_wdata = wd;
            if ($urandom_range(0, 1) == 1) begin
               ia          = $urandom;
               i_line_read = 1'b1;
               i_line_addr = ia;
               run_burst(kind, a, wd, 3, -1);
               rand_beats();
               run_burst(K_IRD, ia, '0, 3, -1);
            end else begin
               run_burst(kind, a, wd, 3, -1);
            end
         end
         // Occasionally leave an idle gap with a stray handshake.
         if ($urandom_range(0, 3) == 0) begin
            mem_resp  = 1'b1;
            mem_rdata = {$urandom, $urandom};
            @(negedge clk);
            mem_resp = 1'b0;
            check_idle("rand_idle");
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/line_mem_arbiter.md
# line_mem_arbiter

Sits between the mp4 core's instruction/data line caches and the testbench burst memory port (mem_read/mem_write/mem_addr/mem_wdata/mem_rdata/mem_resp). It arbitrates one outstanding line request at a time between the I-side and D-side. Each granted request becomes a BEATS-beat burst transfer; read beats are assembled into a full line and returned with a one-cycle response pulse.

## Interface
Parameters:
- BEATS, 4, beats per line burst
- BEAT_W, 64, bits per beat; line width LINE_W = BEATS*BEAT_W (256 by default)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; one clock; reset is asynchronous and active-low
- i_line_read  in  1  I-side line read request, held until i_line_resp
- i_line_addr  in  32  I-side line address
- i_line_rdata  out  LINE_W  returned line, valid when i_line_resp=1
- i_line_resp  out  1  one-cycle completion pulse
- d_line_read  in  1  D-side line read request, held until d_line_resp
- d_line_write  in  1  D-side line writeback request, held until d_line_resp
- d_line_addr  in  32  D-side line address
- d_line_wdata  in  LINE_W  D-side writeback line
- d_line_rdata  out  LINE_W  returned line, valid when d_line_resp=1
- d_line_resp  out  1  one-cycle completion pulse
- mem_read  out  1  burst read active
- mem_write  out  1  burst write active
- mem_addr  out  32  burst base address, line-aligned (low log2(LINE_W/8) bits forced 0)
- mem_wdata  out  BEAT_W  current write beat
- mem_rdata  in  BEAT_W  current read beat, valid when mem_resp=1
- mem_resp  in  1  one beat accepted or delivered this cycle

## Operation
- FSM states: IDLE, I_RD, D_RD, D_WR, DONE.
- IDLE arbitration, sampled each cycle, fixed priority:
  - d_line_write -> D_WR;
  - else d_line_read -> D_RD;
  - else i_line_read -> I_RD.
  - d_line_read and d_line_write together is illegal; write wins.
- On grant, latch the aligned address. For D_WR also latch d_line_wdata. Requester input changes after grant are ignored.
- Beat counter cnt (log2 BEATS bits):
  - cleared on grant;
  - increments on each mem_resp while in I_RD/D_RD/D_WR.
- Reads: on mem_resp, line_buf[cnt*BEAT_W +: BEAT_W] <= mem_rdata.
- Writes: mem_wdata = wr_buf[cnt*BEAT_W +: BEAT_W] (combinational from cnt).
- On mem_resp with cnt==BEATS-1, go to DONE. The owning side's *_line_resp is high for exactly the DONE cycle; DONE -> IDLE unconditionally.
- i_line_rdata and d_line_rdata both drive line_buf. line_buf holds its value until the next read burst overwrites it.
- A D_WR completion pulses d_line_resp; line_buf is unchanged.

## Timing
- Reset (rst=0, asynchronous):
  - state=IDLE, cnt=0, line_buf=0, wr_buf=0, latched addr=0;
  - all outputs 0 (mem_read, mem_write, mem_addr, mem_wdata, both resp, both rdata).
- Reset mid-burst: mem_read/mem_write drop immediately, no resp is issued, and the request is lost. The requester re-requests after reset.
- mem_read=1 in I_RD/D_RD, mem_write=1 in D_WR, both 0 in IDLE/DONE. Both are registered-state outputs.
- mem_addr = latched addr in burst states, 0 otherwise.
- Latency: request high at edge N (in IDLE) -> mem_read/write high from cycle N+1. With back-to-back mem_resp from N+1..N+4, resp is high in cycle N+5. Minimum 6 cycles request-to-resp including DONE.
- mem_resp gaps are allowed between beats; cnt holds and the burst stays asserted.
- mem_resp in IDLE/DONE is ignored.
- Requester must deassert in the cycle after resp. DONE prevents re-grant of the same request on the resp edge.
- A losing requester waits; its request stays pending. Back-to-back bursts are separated by exactly one DONE cycle plus one IDLE cycle.

## Test plan
- I read, addr 0x0000_0064: mem_addr=0x0000_0060. Beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 back-to-back -> i_line_resp one cycle at N+5, i_line_rdata = {0x44..,0x33..,0x22..,0x11..}, d_line_resp stays 0.
- D write, addr 0x0000_1000, wdata beats A,B,C,D with mem_resp gapped by 2 idle cycles -> mem_wdata steps A→B→C→D only on mem_resp, mem_write held throughout, one d_line_resp.
- i_line_read and d_line_read asserted in the same cycle -> D burst first. After d_line_resp, the I burst starts 2 cycles later, I addr correct.
- d_line_addr changed to 0xFFFF_FFE0 mid-burst -> mem_addr keeps the latched value.
- rst low after beat 2 of a read -> mem_read=0 asynchronously, no resp, line_buf=0. After release with request still high, a fresh 4-beat burst completes normally.
- mem_resp pulsed while IDLE -> no state change, no resp, line_buf unchanged.
